// File: rtl/found_bcd_formatter.sv
// found_bcd_formatter: latches the search-engine match address on a done rise and converts it
// to four registered BCD digits by shift-add-3, with not-found and leading-zero-blank coding.
module found_bcd_formatter #(
    parameter int               BIN_W     = 8,
    parameter int               DIGITS    = 4,
    parameter logic [BIN_W-1:0] NOT_FOUND = 8'hFF,
    parameter bit               LZB       = 1'b1
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             done,
    input  logic [BIN_W-1:0] found,
    output logic [3:0]       thousands,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       units,
    output logic             busy,
    output logic             bcd_valid,
    output logic             no_match
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE, NOTF} state_t;

    state_t           state_q, state_d;
    logic             done_d_q, armed_q;
    logic [BIN_W-1:0] bin_sr_q, bin_sr_d;
    logic [BW-1:0]    bcd_sr_q, bcd_sr_d, bcd_adj;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      dig_q, dig_d;
    logic             busy_q, busy_d, valid_q, valid_d, nm_q, nm_d;
    logic [3:1]       blank;
    logic             start;

    // armed_q suppresses start on the first clock after reset so a done held
    // across reset release is treated as already seen, not as a fresh rise
    assign start = done & ~done_d_q & armed_q;

    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] >= 4'd5 ? bcd_sr_q[4*i +: 4] + 4'd3 : bcd_sr_q[4*i +: 4];
    end

    assign blank[3] = LZB && bcd_sr_q[15:12] == 4'd0;
    assign blank[2] = blank[3] && bcd_sr_q[11:8] == 4'd0;
    assign blank[1] = blank[2] && bcd_sr_q[7:4] == 4'd0;

    always_comb begin
        state_d  = state_q;
        bin_sr_d = bin_sr_q;
        bcd_sr_d = bcd_sr_q;
        cnt_d    = cnt_q;
        dig_d    = dig_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        nm_d     = nm_q;
        case (state_q)
            IDLE: if (start) begin
                bin_sr_d = found;
                bcd_sr_d = '0;
                cnt_d    = '0;
                busy_d   = 1'b1;
                state_d  = found == NOT_FOUND ? NOTF : SHIFT;
            end
            SHIFT: begin
                {bcd_sr_d, bin_sr_d} = {bcd_adj, bin_sr_q} << 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(BIN_W - 1) ? UPDATE : SHIFT;
            end
            UPDATE: begin
                dig_d   = {blank[3] ? 4'hF : bcd_sr_q[15:12], blank[2] ? 4'hF : bcd_sr_q[11:8],
                           blank[1] ? 4'hF : bcd_sr_q[7:4], bcd_sr_q[3:0]};
                nm_d    = 1'b0;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            NOTF: begin
                dig_d   = 16'hFFFF;
                nm_d    = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            done_d_q <= 1'b0;
            armed_q  <= 1'b0;
            bin_sr_q <= '0;
            bcd_sr_q <= '0;
            cnt_q    <= '0;
            dig_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            nm_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_d_q <= done;
            armed_q  <= 1'b1;
            bin_sr_q <= bin_sr_d;
            bcd_sr_q <= bcd_sr_d;
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            nm_q     <= nm_d;
        end
    end

    assign thousands = dig_q[15:12];
    assign hundreds  = dig_q[11:8];
    assign tens      = dig_q[7:4];
    assign units     = dig_q[3:0];
    assign busy      = busy_q;
    assign bcd_valid = valid_q;
    assign no_match  = nm_q;
endmodule
